cam_stream_packer: RTL and testbench
====================================

Name: cam_stream_packer

Overview:
- Sits between the camera capture path and the DRAM write engine.
- Takes the camera's fclk-domain 8-bit pixel byte stream and packs bytes into 64-bit words, buffering them in an internal FIFO.
- Presents the words on the valid/ready plus burst_valid interface the DRAM writer consumes.
- Enforces exact per-frame byte counts: pads short frames and discards excess, so every DRAM frame buffer is completely filled.

Parameters:
- FIFO_DEPTH, 64, depth of the word FIFO in 64-bit words; power of two, at least 2*BURST_LEN.
- BURST_LEN, 16, words per AXI burst; burst_valid threshold.
- OVF_W, 16, width of the saturating overflow counter.

Ports:
- fclk  in  1  system clock (the only clock).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms capture at the next vsync.
- stop  in  1  one-cycle pulse; return to IDLE after the current frame completes.
- frame_bytes  in  32  bytes per frame; sampled at start; bits [2:0] ignored (rounded down to a whole word).
- pix_vsync  in  1  one-cycle frame-start pulse from the camera sync logic.
- pix_valid  in  1  pix_data is valid this cycle (no backpressure on this side).
- pix_data  in  8  pixel byte.
- dout_burst_valid  out  1  FIFO holds at least BURST_LEN words, or the frame tail is ready.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer pops a word when dout_valid && dout_ready.
- dout  out  64  FIFO head word; the first byte of the word is in bits [7:0].
- frame_done  out  1  one-cycle pulse when the final word of a frame is popped.
- short_frame  out  1  sticky flag: a frame was padded; cleared by start.
- overflow_cnt  out  OVF_W  saturating count of bytes dropped because the FIFO was full; cleared by start.
- debug_state  out  2  current state encoding.

Behaviour:
- Reset: all outputs 0 and state IDLE. The FIFO, pack register, byte index and counters are cleared. Reset asserted mid-frame discards everything, with no frame_done.
- States: IDLE=0, WAIT_VS=1, CAPTURE=2, PAD=3.
- IDLE:
  - start latches frame_words = frame_bytes[31:3] and goes to WAIT_VS.
  - start while not in IDLE is ignored.
  - frame_words == 0: stay in IDLE.
- WAIT_VS: on pix_vsync, clear word_cnt and byte index, then go to CAPTURE. Bytes arriving before vsync are dropped and not counted.
- CAPTURE:
  - Each pix_valid byte goes into pack[idx*8 +: 8] and idx increments.
  - When idx == 7, the completed word is pushed to the FIFO in the same cycle and word_cnt increments.
  - If the FIFO is full at push, the word is dropped, overflow_cnt += 8 (saturating), and word_cnt still increments, which keeps address alignment.
  - When word_cnt reaches frame_words, later bytes are discarded until the next vsync.
- Early vsync (pix_vsync while word_cnt < frame_words):
  - The partial word is zero-filled and pushed.
  - Then go to PAD and set short_frame.
- PAD:
  - Push one all-zero word per cycle while the FIFO is not full, until word_cnt == frame_words.
  - Camera bytes are ignored in PAD.
- End of frame:
  - When the last word of the frame is pushed, track the tail.
  - frame_done pulses on the cycle that word is popped.
- Next state after the last word is pushed:
  - WAIT_VS, or IDLE if stop was seen during the frame.
  - The end-of-frame vsync itself is consumed as the next frame start only if it arrives after completion.
- Push and pop in the same cycle: allowed in every state, including when the FIFO is full. When full, the pop frees the slot and the push succeeds.
- dout_burst_valid = (count >= BURST_LEN) || (tail_pushed && count > 0).
- Latency: byte 8 of a word to dout_valid is 1 cycle (registered FIFO write, first-word fall-through read).
- Widths:
  - word_cnt is 29 bits.
  - The FIFO count is log2(FIFO_DEPTH)+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package: state encoding localparams (IDLE, WAIT_VS, CAPTURE, PAD) and the WORD_BYTES=8 constant.
- One sub-module: sync_fifo_fwft (parameterised width/depth, with count output), reused by other DRAM stages.

Test Plan:
- Nominal frame: start with frame_bytes=256, vsync, then 256 bytes 0x00..0xFF with dout_ready=1.
  - Expect 32 words; word 0 = 0x0706050403020100.
  - One frame_done pulse on the pop of word 31.
  - short_frame=0 and overflow_cnt=0.
- Burst threshold: dout_ready=0 with 15 words pushed gives burst_valid=0; the 16th word gives burst_valid=1 the next cycle.
- Short frame: frame_bytes=256, vsync, 100 bytes, then vsync.
  - Expect word 12 = bytes 96..99 in [31:0] and zeros above.
  - Words 13..31 are all 0.
  - short_frame=1 and frame_done on the 32nd pop.
- Overflow: FIFO_DEPTH=64, dout_ready=0, frame of 1024 bytes.
  - Expect 64 words held and overflow_cnt=512.
  - word_cnt still reaches 128.
- Long frame plus stop:
  - 264 bytes with frame_bytes=256 gives 32 words, with the last 8 bytes discarded.
  - A stop during the frame leads to IDLE after completion, and a subsequent vsync is ignored.
- Reset mid-frame: assert rst_n=0 after 50 bytes.
  - Expect all outputs 0 immediately (asynchronously).
  - After release: dout_valid=0 and state IDLE.

Source files
------------

// File: rtl/cam_stream_packer_pkg.sv
// rtl/cam_stream_packer_pkg.sv - shared state encoding and byte-packing helpers
package cam_stream_packer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    PAD     = 2'd3
  } state_t;

  localparam int WORD_BYTES = 8;

  // Mask keeping the lowest nbytes bytes of a packed word; nbytes == 0 gives all zeros.
  function automatic logic [63:0] keep_mask(input logic [2:0] nbytes);
    keep_mask = (64'd1 << {nbytes, 3'b000}) - 64'd1;
  endfunction

endpackage

// File: rtl/cam_stream_packer_fifo.sv
// rtl/cam_stream_packer_fifo.sv - first-word fall-through synchronous FIFO with occupancy count
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cam_stream_packer.sv
// rtl/cam_stream_packer.sv - packs camera bytes into 64-bit words with exact per-frame word counts
module cam_stream_packer
  import cam_stream_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int BURST_LEN  = 16,
  parameter int OVF_W      = 16
) (
  input  logic             fclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      frame_bytes,
  input  logic             pix_vsync,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  output logic             dout_burst_valid,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [63:0]      dout,
  output logic             frame_done,
  output logic             short_frame,
  output logic [OVF_W-1:0] overflow_cnt,
  output logic [1:0]       debug_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t          state;
  logic [28:0]     frame_words;
  logic [28:0]     word_cnt;
  logic [2:0]      idx;
  logic [63:0]     pack;
  logic            stop_seen;
  logic [CW-1:0]   tail_left;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_next;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            push_en;
  logic            push_ok;
  logic [63:0]     push_data;
  logic            word_last;
  logic            frame_end;
  logic            unused_bits;

  assign unused_bits = &{1'b0, frame_bytes[2:0]};

  function automatic logic [OVF_W-1:0] sat_add(input logic [OVF_W-1:0] a, input logic [3:0] b);
    logic [OVF_W:0] s;
    s = {1'b0, a} + {{(OVF_W-3){1'b0}}, b};
    return s[OVF_W] ? '1 : s[OVF_W-1:0];
  endfunction

  assign pop        = dout_ready && !fifo_empty;
  assign push_ok    = push_en && (!fifo_full || pop);
  assign word_last  = (word_cnt + 29'd1) == frame_words;
  assign frame_end  = push_en && word_last;
  assign count_next = fifo_count + CW'(push_ok) - CW'(pop);

  always_comb begin
    push_en   = 1'b0;
    push_data = '0;
    case (state)
      CAPTURE: begin
        if (pix_vsync) begin
          push_en   = 1'b1;
          push_data = pack & keep_mask(idx);
        end else if (pix_valid && idx == 3'd7) begin
          push_en   = 1'b1;
          push_data = {pix_data, pack[55:0]};
        end
      end
      // Padding only advances when a slot is actually available.
      PAD:     push_en = !fifo_full || pop;
      default: push_en = 1'b0;
    endcase
  end

  sync_fifo_fwft #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (fclk),
    .rst_n   (rst_n),
    .wr_en   (push_en),
    .wr_data (push_data),
    .rd_en   (dout_ready),
    .rd_data (dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign dout_valid       = !fifo_empty;
  assign dout_burst_valid = (fifo_count >= CW'(BURST_LEN)) || (tail_left != '0 && !fifo_empty);
  assign frame_done       = pop && (tail_left == CW'(1));
  assign debug_state      = state;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      frame_words  <= '0;
      word_cnt     <= '0;
      idx          <= '0;
      pack         <= '0;
      stop_seen    <= 1'b0;
      tail_left    <= '0;
      short_frame  <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      if (pop && tail_left != '0) tail_left <= tail_left - CW'(1);
      if (stop && state != IDLE) stop_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            frame_words  <= frame_bytes[31:3];
            short_frame  <= 1'b0;
            overflow_cnt <= '0;
            stop_seen    <= 1'b0;
            if (frame_bytes[31:3] != '0) state <= WAIT_VS;
          end
        end
        WAIT_VS: begin
          if (stop || stop_seen) begin
            state     <= IDLE;
            stop_seen <= 1'b0;
          end else if (pix_vsync) begin
            word_cnt <= '0;
            idx      <= '0;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (pix_vsync) begin
            word_cnt    <= word_cnt + 29'd1;
            idx         <= '0;
            short_frame <= 1'b1;
            state       <= PAD;
            if (!push_ok) overflow_cnt <= sat_add(overflow_cnt, {1'b0, idx});
          end else if (pix_valid) begin
            pack[idx*8 +: 8] <= pix_data;
            idx              <= idx + 3'd1;
            if (idx == 3'd7) begin
              word_cnt <= word_cnt + 29'd1;
              if (!push_ok) overflow_cnt <= sat_add(overflow_cnt, 4'(WORD_BYTES));
            end
          end
        end
        PAD: begin
          if (push_ok) word_cnt <= word_cnt + 29'd1;
        end
        default: state <= IDLE;
      endcase

      // The tail marker counts how many pops remain until the frame's last held word leaves.
      if (frame_end) begin
        state     <= (stop || stop_seen) ? IDLE : WAIT_VS;
        stop_seen <= 1'b0;
        tail_left <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_cam_stream_packer.sv
// tb/tb_cam_stream_packer.sv - directed self-checking bench for cam_stream_packer
module tb_cam_stream_packer;

  localparam int OVF_W = 16;

  logic             fclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [31:0]      frame_bytes = '0;
  logic             pix_vsync = 1'b0;
  logic             pix_valid = 1'b0;
  logic [7:0]       pix_data = '0;
  logic             dout_ready = 1'b0;
  logic             dout_burst_valid;
  logic             dout_valid;
  logic [63:0]      dout;
  logic             frame_done;
  logic             short_frame;
  logic [OVF_W-1:0] overflow_cnt;
  logic [1:0]       debug_state;

  int tests = 0;
  int fails = 0;
  logic [63:0] got[$];
  logic        done_at[$];
  int          done_cnt = 0;

  cam_stream_packer #(.FIFO_DEPTH(64), .BURST_LEN(16), .OVF_W(OVF_W)) dut (
    .fclk             (fclk),
    .rst_n            (rst_n),
    .start            (start),
    .stop             (stop),
    .frame_bytes      (frame_bytes),
    .pix_vsync        (pix_vsync),
    .pix_valid        (pix_valid),
    .pix_data         (pix_data),
    .dout_burst_valid (dout_burst_valid),
    .dout_valid       (dout_valid),
    .dout_ready       (dout_ready),
    .dout             (dout),
    .frame_done       (frame_done),
    .short_frame      (short_frame),
    .overflow_cnt     (overflow_cnt),
    .debug_state      (debug_state)
  );

  always #5 fclk = ~fclk;

  always @(negedge fclk) begin
    if (rst_n && dout_valid && dout_ready) begin
      got.push_back(dout);
      done_at.push_back(frame_done);
    end
    if (rst_n && frame_done) done_cnt++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge fclk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [31:0] fb);
    frame_bytes = fb; start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic pulse_vsync();
    pix_vsync = 1'b1; cyc(); pix_vsync = 1'b0;
  endtask

  task automatic send_bytes(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1; pix_data = 8'(first + i); cyc();
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_words(input int target, input int bound);
    int k = 0;
    while (got.size() < target && k < bound) begin
      cyc(); k++;
    end
  endtask

  function automatic logic [63:0] pat_word(input int k);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'(8*k + b);
    return w;
  endfunction

  task automatic test_reset();
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_dout_valid: got %0b want 0", dout_valid); end
    tests++; if (dout_burst_valid !== 1'b0) begin fails++; $display("FAIL reset_burst_valid: got %0b want 0", dout_burst_valid); end
    tests++; if (dout !== 64'd0) begin fails++; $display("FAIL reset_dout: got %h want 0", dout); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
    tests++; if (short_frame !== 1'b0) begin fails++; $display("FAIL reset_short_frame: got %0b want 0", short_frame); end
    tests++; if (overflow_cnt !== 16'd0) begin fails++; $display("FAIL reset_overflow_cnt: got %0d want 0", overflow_cnt); end
    tests++; if (debug_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", debug_state); end
  endtask

  task automatic test_nominal();
    int base = got.size();
    int d0 = done_cnt;
    int bad = 0;
    dout_ready = 1'b1;
    pulse_start(32'd256);
    tests++; if (debug_state !== 2'd1) begin fails++; $display("FAIL nominal_wait_vs: got %0d want 1", debug_state); end
    pulse_vsync();
    tests++; if (debug_state !== 2'd2) begin fails++; $display("FAIL nominal_capture: got %0d want 2", debug_state); end
    send_bytes(0, 256);
    wait_words(base + 32, 20);
    cyc(3);
    tests++; if (got.size() != base + 32) begin fails++; $display("FAIL nominal_count: got %0d want 32", got.size() - base); end
    if (got.size() < base + 32) bad = 32;
    else for (int k = 0; k < 32; k++) if (got[base+k] !== pat_word(k)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL nominal_data: got %0d bad words want 0", bad); end
    tests++; if (got.size() > base && got[base] !== 64'h0706050403020100) begin fails++; $display("FAIL nominal_word0: got %h want 0706050403020100", got[base]); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL nominal_done_count: got %0d want 1", done_cnt - d0); end
    tests++; if (got.size() >= base + 32 && done_at[base+31] !== 1'b1) begin fails++; $display("FAIL nominal_done_pos: got %0b want 1", done_at[base+31]); end
    tests++; if (short_frame !== 1'b0 || overflow_cnt !== 16'd0) begin fails++; $display("FAIL nominal_flags: got short=%0b ovf=%0d want 0 0", short_frame, overflow_cnt); end
    tests++; if (debug_state !== 2'd1) begin fails++; $display("FAIL nominal_end_state: got %0d want 1", debug_state); end
  endtask

  task automatic test_burst();
    int base;
    int d0 = done_cnt;
    pulse_stop();
    tests++; if (debug_state !== 2'd0) begin fails++; $display("FAIL burst_stop_idle: got %0d want 0", debug_state); end
    dout_ready = 1'b0;
    base = got.size();
    pulse_start(32'd256);
    pulse_vsync();
    send_bytes(0, 7);
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL burst_latency_pre: got %0b want 0", dout_valid); end
    send_bytes(7, 1);
    tests++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL burst_latency: got %0b want 1", dout_valid); end
    send_bytes(8, 112);
    tests++; if (dout_burst_valid !== 1'b0) begin fails++; $display("FAIL burst_15_words: got %0b want 0", dout_burst_valid); end
    send_bytes(120, 8);
    tests++; if (dout_burst_valid !== 1'b1) begin fails++; $display("FAIL burst_16_words: got %0b want 1", dout_burst_valid); end
    dout_ready = 1'b1;
    wait_words(base + 16, 40);
    send_bytes(128, 64);
    cyc(3);
    dout_ready = 1'b0;
    send_bytes(192, 56);
    tests++; if (dout_burst_valid !== 1'b0) begin fails++; $display("FAIL burst_pre_tail: got %0b want 0", dout_burst_valid); end
    send_bytes(248, 8);
    tests++; if (dout_burst_valid !== 1'b1) begin fails++; $display("FAIL burst_tail: got %0b want 1", dout_burst_valid); end
    dout_ready = 1'b1;
    wait_words(base + 32, 40);
    cyc(3);
    tests++; if (got.size() != base + 32) begin fails++; $display("FAIL burst_count: got %0d want 32", got.size() - base); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL burst_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_short();
    int base;
    int d0 = done_cnt;
    int bad = 0;
    pulse_stop();
    base = got.size();
    dout_ready = 1'b1;
    pulse_start(32'd256);
    pulse_vsync();
    send_bytes(0, 100);
    pulse_vsync();
    wait_words(base + 32, 100);
    cyc(3);
    tests++; if (got.size() != base + 32) begin fails++; $display("FAIL short_count: got %0d want 32", got.size() - base); end
    if (got.size() < base + 32) bad = 32;
    else begin
      for (int k = 0; k < 12; k++) if (got[base+k] !== pat_word(k)) bad++;
      for (int k = 13; k < 32; k++) if (got[base+k] !== 64'd0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL short_data: got %0d bad words want 0", bad); end
    tests++; if (got.size() > base + 12 && got[base+12] !== 64'h0000000063626160) begin fails++; $display("FAIL short_word12: got %h want 0000000063626160", got[base+12]); end
    tests++; if (short_frame !== 1'b1) begin fails++; $display("FAIL short_flag: got %0b want 1", short_frame); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL short_done_count: got %0d want 1", done_cnt - d0); end
    tests++; if (got.size() >= base + 32 && done_at[base+31] !== 1'b1) begin fails++; $display("FAIL short_done_pos: got %0b want 1", done_at[base+31]); end
    tests++; if (debug_state !== 2'd1) begin fails++; $display("FAIL short_end_state: got %0d want 1", debug_state); end
  endtask

  task automatic test_overflow();
    int base;
    pulse_stop();
    dout_ready = 1'b0;
    base = got.size();
    pulse_start(32'd1024);
    tests++; if (short_frame !== 1'b0) begin fails++; $display("FAIL ovf_short_cleared: got %0b want 0", short_frame); end
    pulse_vsync();
    send_bytes(0, 1024);
    tests++; if (overflow_cnt !== 16'd512) begin fails++; $display("FAIL ovf_count: got %0d want 512", overflow_cnt); end
    tests++; if (debug_state !== 2'd1) begin fails++; $display("FAIL ovf_word_cnt_done: got %0d want 1", debug_state); end
    tests++; if (dout_burst_valid !== 1'b1) begin fails++; $display("FAIL ovf_burst: got %0b want 1", dout_burst_valid); end
    dout_ready = 1'b1;
    wait_words(base + 64, 100);
    cyc(3);
    tests++; if (got.size() != base + 64) begin fails++; $display("FAIL ovf_held: got %0d want 64", got.size() - base); end
    tests++; if (got.size() >= base + 64 && got[base+63] !== pat_word(63)) begin fails++; $display("FAIL ovf_word63: got %h want %h", got[base+63], pat_word(63)); end
  endtask

  task automatic test_long_stop();
    int base;
    int d0 = done_cnt;
    int bad = 0;
    pulse_stop();
    dout_ready = 1'b1;
    base = got.size();
    pulse_start(32'd256);
    pulse_vsync();
    send_bytes(0, 130);
    pulse_stop();
    send_bytes(130, 134);
    tests++; if (debug_state !== 2'd0) begin fails++; $display("FAIL long_idle: got %0d want 0", debug_state); end
    pulse_vsync();
    cyc(2);
    tests++; if (debug_state !== 2'd0) begin fails++; $display("FAIL long_vsync_ignored: got %0d want 0", debug_state); end
    wait_words(base + 32, 50);
    cyc(3);
    tests++; if (got.size() != base + 32) begin fails++; $display("FAIL long_count: got %0d want 32", got.size() - base); end
    if (got.size() < base + 32) bad = 32;
    else for (int k = 0; k < 32; k++) if (got[base+k] !== pat_word(k)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL long_data: got %0d bad words want 0", bad); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL long_done_count: got %0d want 1", done_cnt - d0); end
    tests++; if (overflow_cnt !== 16'd0) begin fails++; $display("FAIL long_ovf: got %0d want 0", overflow_cnt); end
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b0;
    pulse_start(32'd256);
    pulse_vsync();
    send_bytes(0, 50);
    tests++; if (dout_valid !== 1'b1 || debug_state !== 2'd2) begin fails++; $display("FAIL rmid_pre: got valid=%0b state=%0d want 1 2", dout_valid, debug_state); end
    rst_n = 1'b0;
    #1;
    tests++; if (dout_valid !== 1'b0 || dout_burst_valid !== 1'b0 || dout !== 64'd0) begin fails++; $display("FAIL rmid_async_data: got valid=%0b burst=%0b dout=%h want 0", dout_valid, dout_burst_valid, dout); end
    tests++; if (debug_state !== 2'd0 || frame_done !== 1'b0 || short_frame !== 1'b0 || overflow_cnt !== 16'd0) begin fails++; $display("FAIL rmid_async_status: got state=%0d done=%0b short=%0b ovf=%0d want 0", debug_state, frame_done, short_frame, overflow_cnt); end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL rmid_post_valid: got %0b want 0", dout_valid); end
    tests++; if (debug_state !== 2'd0) begin fails++; $display("FAIL rmid_post_state: got %0d want 0", debug_state); end
  endtask

  initial begin
    cyc(3);
    test_reset();
    rst_n = 1'b1;
    cyc(2);
    test_nominal();
    test_burst();
    test_short();
    test_overflow();
    test_long_stop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
